// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: FSM state encoding, SPI mode
// encodings and the minimum sclk phase length in system clock cycles.
// Optional feature macro: SPI_SLAVE_SCLK_FILTER_EN (sclk glitch filter).
package spi_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Shortest sclk phase (in clock cycles) the responder can follow
`ifdef SPI_SLAVE_SCLK_FILTER_EN
    localparam int MIN_PHASE = 5;
`else
    localparam int MIN_PHASE = 4;
`endif

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous pad input. RESET_VAL sets the
// value both flops take during reset (1 for an active-low select, 0 otherwise).
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din_i,
    output logic dout_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
        end
    end

    assign dout_o = sync_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI responder: oversamples sclk/ss_n/mosi with the system clock,
// deserialises D_WIDTH-bit words onto rx_data and serialises tx_data onto
// miso, MSB first, in any CPOL/CPHA mode with back-to-back words.
// Optional feature macro: SPI_SLAVE_SCLK_FILTER_EN -- when defined, the
// synchronised sclk must be stable for two samples before it is accepted.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpol,
    input  logic               cpha,
    input  logic [D_WIDTH-1:0] tx_data,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               tx_ack,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               busy
);

    localparam int CNT_W = $clog2(D_WIDTH + 1);

    logic sclk_sync;
    logic ss_n_sync;
    logic mosi_sync;

    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clock (clock),
        .reset (reset),
        .din_i (sclk),
        .dout_o(sclk_sync)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_sync_ss_n (
        .clock (clock),
        .reset (reset),
        .din_i (ss_n),
        .dout_o(ss_n_sync)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clock (clock),
        .reset (reset),
        .din_i (mosi),
        .dout_o(mosi_sync)
    );

    // ------------------------------------------------------------------
    // sclk edge detection
    // ------------------------------------------------------------------
    logic sclk_q;      // previous accepted sclk level
    logic sclk_f;      // accepted (optionally filtered) sclk level
    logic sample_q;    // registered sample-edge strobe
    logic shift_q;     // registered shift-edge strobe

`ifdef SPI_SLAVE_SCLK_FILTER_EN
    logic sclk_prev_q;

    // Remember the last synchronised sample so a level is only accepted
    // once it has been seen twice in a row
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_sync;
        end
    end

    assign sclk_f = (sclk_sync == sclk_prev_q) ? sclk_sync : sclk_q;
`else
    assign sclk_f = sclk_sync;
`endif

    logic sclk_edge;
    logic lead_edge;
    logic trail_edge;

    assign sclk_edge  = (sclk_f != sclk_q);
    assign lead_edge  = sclk_edge && (sclk_f != cpol);
    assign trail_edge = sclk_edge && (sclk_f == cpol);

    // Register the edge strobes; cpha picks which edge samples mosi
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            sclk_q   <= sclk_f;
            sample_q <= cpha ? trail_edge : lead_edge;
            shift_q  <= cpha ? lead_edge  : trail_edge;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and shift registers
    // ------------------------------------------------------------------
    logic [0:0]         state_q,    state_d;
    logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [D_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [D_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [D_WIDTH-1:0] rx_data_q,  rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               tx_ack_q,   tx_ack_d;
    logic               miso_q,     miso_d;

    // Next-state logic: select/deselect, bit sampling, word boundary, shifting
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!ss_n_sync) begin
                    state_d    = ST_ACTIVE;
                    tx_shift_d = tx_data;
                    tx_ack_d   = 1'b1;
                end
            end
            default: begin
                if (ss_n_sync) begin
                    // Deselect beats any pending edge; partial word dropped
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (sample_q) begin
                    rx_shift_d = {rx_shift_q[D_WIDTH-2:0], mosi_sync};
                    if (bit_cnt_q == CNT_W'(D_WIDTH - 1)) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        tx_shift_d = tx_data;
                        tx_ack_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_q && (bit_cnt_q != '0)) begin
                    // A shift edge right after a load must keep the new MSB
                    tx_shift_d = {tx_shift_q[D_WIDTH-2:0], 1'b0};
                end
            end
        endcase

        miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[D_WIDTH-1] : 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            miso_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            miso_q     <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign tx_ack   = tx_ack_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == ST_ACTIVE);

endmodule
